// File: rtl/bcd_to_binary_pkg.sv
// Shared types and constants for the BCD-to-binary converter.
// Digit width, reverse double-dabble correction constants and the FSM state enum.
package bcd_pkg;

  localparam int         DIG_W       = 4;
  localparam logic [3:0] CORR_THRESH = 4'd8;
  localparam logic [3:0] CORR_VAL    = 4'd3;
  localparam logic [3:0] DIG_MAX     = 4'd9;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

endpackage

// File: rtl/bcd_to_binary_if.sv
// Start/done handshake bundle between the input logic and the converter.
// start is sampled only while ready=1; done is a one-cycle pulse; bin_out/err hold until the next result.
interface bcd_to_binary_if #(
  parameter int NDIG = 3,
  parameter int BW   = 10
) ();

  logic              start;
  logic [4*NDIG-1:0] bcd_in;
  logic              ready;
  logic              busy;
  logic              done;
  logic [BW-1:0]     bin_out;
  logic              err;

  modport master (
    output start, bcd_in,
    input  ready, busy, done, bin_out, err
  );

  modport slave (
    input  start, bcd_in,
    output ready, busy, done, bin_out, err
  );

endinterface

// File: rtl/bcd_to_binary_sub3.sv
// Per-digit correction for reverse double-dabble: subtract 3 from any digit >= 8.
// Inputs after a shift are at most 12, so the subtract never wraps.
module sub3
  import bcd_pkg::*;
(
  input  logic [DIG_W-1:0] din_i,
  output logic [DIG_W-1:0] dout_o
);

  assign dout_o = (din_i >= CORR_THRESH) ? (din_i - CORR_VAL) : din_i;

endmodule

// File: rtl/bcd_to_binary.sv
// Sequential BCD-to-binary converter using reverse double-dabble, one result bit per clock.
// Illegal digits (>9) skip the shift phase and report err with a zero result.
module bcd_to_binary
  import bcd_pkg::*;
#(
  parameter int NDIG = 3,
  parameter int BW   = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  bcd_to_binary_if.slave        bus,
  output state_e                state_o
);

  localparam int DW = DIG_W * NDIG;
  localparam int TW = DW + BW;
  localparam int CW = (BW > 1) ? $clog2(BW) : 1;

  state_e          state_q, state_d;
  logic [DW-1:0]   bcd_q, bcd_d;
  logic [BW-1:0]   bin_q, bin_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [BW-1:0]   bin_out_q, bin_out_d;
  logic            err_q, err_d;

  logic [TW-1:0]   shifted;
  logic [DW-1:0]   bcd_sh;
  logic [BW-1:0]   bin_sh;
  logic [DW-1:0]   bcd_fix;
  logic [NDIG-1:0] digit_bad;
  logic            any_bad;

  // bcd and bin form one register for the shift; bcd LSB falls into bin MSB.
  assign shifted = {bcd_q, bin_q} >> 1;
  assign bcd_sh  = shifted[TW-1:BW];
  assign bin_sh  = shifted[BW-1:0];

  for (genvar g = 0; g < NDIG; g++) begin : g_digit
    sub3 u_sub3 (
      .din_i  (bcd_sh[g*DIG_W +: DIG_W]),
      .dout_o (bcd_fix[g*DIG_W +: DIG_W])
    );
    assign digit_bad[g] = (bus.bcd_in[g*DIG_W +: DIG_W] > DIG_MAX);
  end

  assign any_bad = |digit_bad;

  always_comb begin
    state_d   = state_q;
    bcd_d     = bcd_q;
    bin_d     = bin_q;
    cnt_d     = cnt_q;
    bin_out_d = bin_out_q;
    err_d     = err_q;
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          bcd_d = bus.bcd_in;
          bin_d = '0;
          cnt_d = CW'(BW - 1);
          if (any_bad) begin
            state_d   = DONE;
            err_d     = 1'b1;
            bin_out_d = '0;
          end else begin
            state_d = SHIFT;
          end
        end
      end
      SHIFT: begin
        bcd_d = bcd_fix;
        bin_d = bin_sh;
        if (cnt_q == '0) begin
          state_d   = DONE;
          bin_out_d = bin_sh;
          err_d     = 1'b0;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      bcd_q     <= '0;
      bin_q     <= '0;
      cnt_q     <= '0;
      bin_out_q <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      bcd_q     <= bcd_d;
      bin_q     <= bin_d;
      cnt_q     <= cnt_d;
      bin_out_q <= bin_out_d;
      err_q     <= err_d;
    end
  end

  assign bus.ready   = (state_q == IDLE);
  assign bus.busy    = (state_q == SHIFT);
  assign bus.done    = (state_q == DONE);
  assign bus.bin_out = bin_out_q;
  assign bus.err     = err_q;
  assign state_o     = state_q;

`ifndef SYNTHESIS
  // A legal input must be fully drained out of the digit register after the last shift.
  a_bcd_drained: assert property (@(posedge clk) disable iff (rst)
    (state_q == SHIFT && cnt_q == '0) |-> (bcd_fix == '0));
`endif

endmodule

// File: tb/tb_bcd_to_binary.sv
// Directed bench for bcd_to_binary: latency, error path, ignored starts, reset abort, round trip.
module tb_bcd_to_binary;
  import bcd_pkg::*;

  localparam int NDIG = 3;
  localparam int BW   = 10;

  logic   clk = 1'b0;
  logic   rst;
  state_e state_w;

  int total = 0;
  int bad   = 0;
  logic [BW:0] exp_q[$];

  bcd_to_binary_if #(.NDIG(NDIG), .BW(BW)) bus ();

  bcd_to_binary #(.NDIG(NDIG), .BW(BW)) dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus),
    .state_o (state_w)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic chk_idle_outputs(input string tag, input logic [BW-1:0] exp_bin, input logic exp_err);
    chk({tag, "_ready"}, 32'(bus.ready), 32'd1);
    chk({tag, "_busy"},  32'(bus.busy),  32'd0);
    chk({tag, "_done"},  32'(bus.done),  32'd0);
    chk({tag, "_err"},   32'(bus.err),   32'(exp_err));
    chk({tag, "_bin"},   32'(bus.bin_out), 32'(exp_bin));
    chk({tag, "_state"}, 32'(state_w),   32'(IDLE));
  endtask

  // One full conversion starting from IDLE; checks latency, busy length, result, and return to ready.
  task automatic convert(input string tag, input logic [11:0] bcd,
                         input logic [BW-1:0] exp_bin, input logic exp_err);
    int          lat;
    int          busy_n;
    logic        seen;
    logic [BW:0] e;
    exp_q.push_back({exp_err, exp_bin});
    @(negedge clk);
    bus.start  = 1'b1;
    bus.bcd_in = bcd;
    @(negedge clk);
    bus.start  = 1'b0;
    bus.bcd_in = ~bcd;
    lat    = 1;
    busy_n = 0;
    seen   = 1'b0;
    while (lat <= 20 && !seen) begin
      chk({tag, "_onehot"}, 32'($countones({bus.ready, bus.busy, bus.done})), 32'd1);
      if (bus.busy) busy_n++;
      if (bus.done) seen = 1'b1;
      else begin
        @(negedge clk);
        lat++;
      end
    end
    e = exp_q.pop_front();
    if (!seen) begin
      chk({tag, "_timeout"}, 32'd0, 32'd1);
    end else begin
      chk({tag, "_latency"}, 32'(lat), exp_err ? 32'd1 : 32'(BW + 1));
      chk({tag, "_busycyc"}, 32'(busy_n), exp_err ? 32'd0 : 32'(BW));
      chk({tag, "_bin"}, 32'(bus.bin_out), 32'(e[BW-1:0]));
      chk({tag, "_err"}, 32'(bus.err), 32'(e[BW]));
      @(negedge clk);
      chk({tag, "_ready_after"}, 32'(bus.ready), 32'd1);
    end
  endtask

  initial begin
    int          ndone;
    int          first_i;
    int          second_i;
    logic [BW-1:0] got_bin;
    logic [11:0] vec;

    rst        = 1'b1;
    bus.start  = 1'b0;
    bus.bcd_in = '0;
    repeat (3) @(negedge clk);
    chk_idle_outputs("reset", '0, 1'b0);
    rst = 1'b0;

    convert("h999", 12'h999, 10'h3E7, 1'b0);
    convert("h000", 12'h000, 10'h000, 1'b0);
    convert("h255", 12'h255, 10'h0FF, 1'b0);
    convert("h001", 12'h001, 10'h001, 1'b0);
    convert("h512", 12'h512, 10'h200, 1'b0);
    convert("h9A5", 12'h9A5, 10'h000, 1'b1);
    convert("h100", 12'h100, 10'd100, 1'b0);
    convert("h00F", 12'h00F, 10'h000, 1'b1);
    convert("hA00", 12'hA00, 10'h000, 1'b1);

    // Extra start pulses during the conversion must be ignored.
    @(negedge clk);
    bus.start  = 1'b1;
    bus.bcd_in = 12'h123;
    ndone   = 0;
    got_bin = '0;
    for (int i = 1; i <= 16; i++) begin
      @(negedge clk);
      bus.start  = (i == 3 || i == 7);
      bus.bcd_in = 12'h999;
      if (bus.done) begin
        ndone++;
        got_bin = bus.bin_out;
      end
    end
    bus.start = 1'b0;
    chk("ignored_start_ndone", 32'(ndone), 32'd1);
    chk("ignored_start_bin", 32'(got_bin), 32'd123);

    // Held start: a new accept every BW+2 cycles.
    @(negedge clk);
    bus.start  = 1'b1;
    bus.bcd_in = 12'h042;
    ndone    = 0;
    first_i  = 0;
    second_i = 0;
    got_bin  = '0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (bus.done) begin
        ndone++;
        got_bin = bus.bin_out;
        if (ndone == 1) first_i = i;
        if (ndone == 2) second_i = i;
      end
    end
    bus.start = 1'b0;
    chk("cont_ndone", 32'(ndone), 32'd3);
    chk("cont_first", 32'(first_i), 32'(BW + 1));
    chk("cont_spacing", 32'(second_i - first_i), 32'(BW + 2));
    chk("cont_bin", 32'(got_bin), 32'd42);
    for (int i = 0; i < 20 && !bus.ready; i++) @(negedge clk);
    chk("cont_drain_ready", 32'(bus.ready), 32'd1);

    // Reset mid-conversion aborts without a done pulse.
    @(negedge clk);
    bus.start  = 1'b1;
    bus.bcd_in = 12'h876;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (4) @(negedge clk);
    chk("abort_busy_before", 32'(bus.busy), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk_idle_outputs("abort", '0, 1'b0);
    ndone = 0;
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      if (bus.done) ndone++;
    end
    chk("abort_no_done", 32'(ndone), 32'd0);
    convert("h042", 12'h042, 10'd42, 1'b0);

    // Round trip over 0..255 with the BCD formed arithmetically.
    for (int v = 0; v < 256; v++) begin
      vec = {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
      convert($sformatf("rt%0d", v), vec, 10'(v), 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
